// File: rtl/periph_arbiter.sv
// Round-robin arbiter sharing the peripheral_io command port.
// One transaction in flight, 4-phase handshake, per-phase timeout.
module periph_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_cmd,
  input  logic [16*N_REQ-1:0]  req_word,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [15:0]          rdata,
  output logic                 busy,
  output logic [2:0]           grant_idx,
  output logic [15:0]          p_cmd,
  output logic [15:0]          p_word,
  output logic                 p_request,
  input  logic                 p_response,
  input  logic [15:0]          p_keycode
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [2:0]      ptr;
  logic [2:0]      gnt;
  logic            found;
  logic [7:0]      vpad;
  logic [127:0]    cmd_pad;
  logic [127:0]    word_pad;
  logic [CW-1:0]   cnt;
  logic            tmo;
  logic            err_flag;

  logic            ld_grant;
  logic            cap;
  logic            clr_rdata;
  logic            req_clr;
  logic            cnt_inc;
  logic            set_err;

  assign vpad     = 8'(req_valid);
  assign cmd_pad  = 128'(req_cmd);
  assign word_pad = 128'(req_word);
  assign tmo      = (cnt == CW'(TIMEOUT - 1));
  assign busy     = (state != S_IDLE);
  assign err      = (state == S_DONE) && err_flag;

  // First valid requester scanning upward from the one after ptr
  always_comb begin
    gnt   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && vpad[3'((int'(ptr) + k) % N_REQ)]) begin
        found = 1'b1;
        gnt   = 3'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  // Done pulse decoded onto the granted requester's bit
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      done[i] = (state == S_DONE) && (grant_idx == 3'(i));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath controls
  always_comb begin
    state_n   = state;
    ld_grant  = 1'b0;
    cap       = 1'b0;
    clr_rdata = 1'b0;
    req_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req_valid) begin
          ld_grant = 1'b1;
          state_n  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (p_response) begin
          cap     = 1'b1;
          req_clr = 1'b1;
          state_n = S_RELEASE;
        end else if (tmo) begin
          req_clr   = 1'b1;
          set_err   = 1'b1;
          clr_rdata = 1'b1;
          state_n   = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RELEASE: begin
        if (!p_response) begin
          state_n = S_DONE;
        end else if (tmo) begin
          set_err = 1'b1;
          state_n = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Grant, peripheral port, capture, counter and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= 3'(N_REQ - 1);
      grant_idx <= 3'd0;
      p_cmd     <= 16'h0000;
      p_word    <= 16'h0000;
      p_request <= 1'b0;
      rdata     <= 16'h0000;
      cnt       <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (ld_grant) begin
        ptr       <= gnt;
        grant_idx <= gnt;
        p_cmd     <= cmd_pad[{gnt, 4'b0000} +: 16];
        p_word    <= word_pad[{gnt, 4'b0000} +: 16];
        p_request <= 1'b1;
      end else if (req_clr) begin
        p_request <= 1'b0;
      end
      if (cap)            rdata <= p_keycode;
      else if (clr_rdata) rdata <= 16'h0000;
      if (state_n != state) cnt <= '0;
      else if (cnt_inc)     cnt <= cnt + CW'(1);
      if (set_err)              err_flag <= 1'b1;
      else if (state == S_DONE) err_flag <= 1'b0;
    end
  end

endmodule
